mips32_fetch_queue: RTL and testbench

Instruction-fetch front end for the pipelined MIPS32 core: owns the program counter, issues word reads to a synchronous instruction memory, and buffers fetched instructions with their next-PC values in a small prefetch queue. It sits directly upstream of the ID stage, feeding {IR, NPC} pairs over a valid/ready handshake. It accepts branch redirects from the EX/MEM boundary, which flush all buffered and in-flight fetches.

---
 rtl/mips32_fetch_queue.sv | 124 ++++++++++++
 tb/tb_mips32_fetch_queue.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mips32_fetch_queue.sv
// mips32_fetch_queue
// Instruction-fetch front end for the pipelined MIPS32 core. Owns the PC,
// issues word reads to a synchronous instruction memory, and buffers the
// fetched {IR, NPC} pairs in a small circular prefetch queue that feeds the
// ID stage over a valid/ready handshake. Branch redirects from EX/MEM flush
// both the queue and any fetch whose data is still on its way back.

module mips32_fetch_queue #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned ADDR_W   = 10,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     imem_rd,
    output logic [ADDR_W-1:0]        imem_addr,
    input  logic [31:0]              imem_data,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    input  logic                     halt,
    output logic                     id_valid,
    input  logic                     id_ready,
    output logic [31:0]              id_ir,
    output logic [31:0]              id_npc,
    output logic [$clog2(DEPTH):0]   fq_count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    // Occupancy is compared one bit wider so count + inflight cannot overflow.
    localparam logic [CNT_W:0] DEPTH_LIMIT = (CNT_W + 1)'(DEPTH);

    logic [31:0]      pc;
    logic             inflight;
    logic [31:0]      inflight_pc;

    logic [31:0]      q_ir  [DEPTH];
    logic [31:0]      q_npc [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic [CNT_W:0]   occupancy;
    logic             issue;
    logic             push;
    logic             pop;
    logic             not_empty;

    // Handshake and issue decisions; redirect masks issue, push and the ID
    // output so nothing moves in a flush cycle.
    always_comb begin
        occupancy = {1'b0, count} + {{CNT_W{1'b0}}, inflight};
        issue     = ~reset & ~halt & ~redirect_valid & (occupancy < DEPTH_LIMIT);
        push      = inflight & ~redirect_valid;
        not_empty = (count != '0);
        id_valid  = not_empty & ~redirect_valid;
        pop       = id_valid & id_ready;
    end

    // Output drive: memory address follows the PC, head entry reads as zero
    // whenever the queue is empty.
    always_comb begin
        imem_rd   = issue;
        imem_addr = pc[ADDR_W-1:0];
        fq_count  = count;
        id_ir     = not_empty ? q_ir[rd_ptr]  : 32'h0;
        id_npc    = not_empty ? q_npc[rd_ptr] : 32'h0;
    end

    // PC and in-flight tracking; a redirect retargets the PC and forgets the
    // outstanding fetch so its response is never pushed.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= 32'h0;
        end else if (redirect_valid) begin
            pc          <= redirect_pc;
            inflight    <= 1'b0;
        end else begin
            inflight <= issue;
            if (issue) begin
                pc          <= pc + 32'd1;
                inflight_pc <= pc;
            end
        end
    end

    // Queue pointers and occupancy; simultaneous push and pop leaves the
    // count alone while both pointers advance.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect_valid) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage; contents need no reset because the count gates the output.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            q_ir[wr_ptr]  <= imem_data;
            q_npc[wr_ptr] <= inflight_pc + 32'd1;
        end
    end

endmodule

// File: tb/tb_mips32_fetch_queue.sv
// tb_mips32_fetch_queue
// Directed bench for the fetch queue. A behavioural instruction memory
// returns 32'hA000_0000 + address one cycle after each strobe. Expected
// deliveries go into a scoreboard queue; a monitor pops and compares on
// every ID transfer while the main thread checks control outputs directly.

module tb_mips32_fetch_queue;

    logic        clk;
    logic        reset;
    logic        imem_rd;
    logic [9:0]  imem_addr;
    logic [31:0] imem_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        halt;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_ir;
    logic [31:0] id_npc;
    logic [2:0]  fq_count;

    int          errors;
    int          checks;
    int          sb_errors;
    int          sb_checks;
    int          max_cnt;
    logic [63:0] sb [$];
    logic [63:0] sb_exp;

    mips32_fetch_queue #(
        .DEPTH    (4),
        .ADDR_W   (10),
        .RESET_PC (32'h0)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_rd        (imem_rd),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .halt           (halt),
        .id_valid       (id_valid),
        .id_ready       (id_ready),
        .id_ir          (id_ir),
        .id_npc         (id_npc),
        .fq_count       (fq_count)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [31:0] mem_word(input logic [9:0] a);
        return 32'hA000_0000 + {22'd0, a};
    endfunction

    // Synchronous instruction memory; a recognisable junk value appears when
    // no read was strobed so a spurious push shows up in the data.
    always @(posedge clk) begin
        imem_data <= imem_rd ? mem_word(imem_addr) : 32'hBAD0_0000;
    end

    // Scoreboard monitor: every ID transfer must match the oldest expectation.
    always @(negedge clk) begin
        if (!reset && id_valid && id_ready) begin
            sb_checks++;
            if (sb.size() == 0) begin
                sb_errors++;
                $display("[TB] FAIL sb_unexpected: got ir=%h npc=%h, required no transfer", id_ir, id_npc);
            end else begin
                sb_exp = sb.pop_front();
                if ({id_ir, id_npc} !== sb_exp) begin
                    sb_errors++;
                    $display("[TB] FAIL sb_entry: got ir=%h npc=%h, required ir=%h npc=%h",
                             id_ir, id_npc, sb_exp[63:32], sb_exp[31:0]);
                end
            end
        end
    end

    // Hard bound on run time.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic rst, input logic rv, input logic [31:0] rpc,
                                 input logic h, input logic rdy);
        reset          = rst;
        redirect_valid = rv;
        redirect_pc    = rpc;
        halt           = h;
        id_ready       = rdy;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h, required %h", name, actual, expected);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic expectEntry(input logic [31:0] npc);
        logic [31:0] a;
        a = npc - 32'd1;
        sb.push_back({mem_word(a[9:0]), npc});
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
            cycle();
        end
    endtask

    task automatic doReset();
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        cycle();
        cycle();
        checkOutput("rst_imem_rd",   32'(imem_rd),   32'h0);
        checkOutput("rst_imem_addr", 32'(imem_addr), 32'h0);
        checkOutput("rst_id_valid",  32'(id_valid),  32'h0);
        checkOutput("rst_id_ir",     id_ir,          32'h0);
        checkOutput("rst_id_npc",    id_npc,         32'h0);
        checkOutput("rst_fq_count",  32'(fq_count),  32'h0);
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        sb_errors = 0;
        sb_checks = 0;
        max_cnt   = 0;
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);

        // Straight-line fill with ID stalled, then stream with ID ready.
        doReset();
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
            #1;
            checkOutput("fill_imem_rd",   32'(imem_rd),   (i < 4) ? 32'h1 : 32'h0);
            checkOutput("fill_imem_addr", 32'(imem_addr), (i < 4) ? 32'(i) : 32'h4);
            cycle();
        end
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        checkOutput("fill_count", 32'(fq_count), 32'h4);
        checkOutput("fill_valid", 32'(id_valid), 32'h1);
        checkOutput("fill_ir",    id_ir,         32'hA000_0000);
        checkOutput("fill_npc",   id_npc,        32'h1);
        for (int n = 1; n <= 10; n++) expectEntry(32'(n));
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
            #1;
            checkOutput("stream_nogap", 32'(id_valid), 32'h1);
            cycle();
        end
        idle(3);
        checkOutput("stream_drained", 32'(sb.size()), 32'h0);

        // Backpressure: id_ready alternates for 20 cycles from a full queue.
        doReset();
        idle(6);
        for (int n = 1; n <= 10; n++) expectEntry(32'(n));
        for (int i = 0; i < 20; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, (i % 2) == 0);
            #1;
            if (int'(fq_count) > max_cnt) max_cnt = int'(fq_count);
            cycle();
        end
        idle(3);
        checkOutput("bp_drained",   32'(sb.size()), 32'h0);
        checkOutput("bp_max_count", 32'(max_cnt),   32'h4);

        // Redirect flush: queue holds npc 5..7 with npc 8 in flight.
        doReset();
        idle(5);
        for (int n = 1; n <= 4; n++) expectEntry(32'(n));
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
            cycle();
        end
        idle(1);
        applyStimulus(1'b0, 1'b1, 32'h40, 1'b0, 1'b0);
        #1;
        checkOutput("flush_count_before", 32'(fq_count), 32'h3);
        checkOutput("flush_valid_n",      32'(id_valid), 32'h0);
        cycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        checkOutput("flush_valid_n1", 32'(id_valid),  32'h0);
        checkOutput("flush_count",    32'(fq_count),  32'h0);
        checkOutput("flush_imem_rd",  32'(imem_rd),   32'h1);
        checkOutput("flush_addr",     32'(imem_addr), 32'h40);
        cycle();
        #1;
        checkOutput("flush_valid_n2", 32'(id_valid), 32'h0);
        cycle();
        for (int n = 'h41; n <= 'h43; n++) expectEntry(32'(n));
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
            #1;
            if (i == 0) begin
                checkOutput("flush_tgt_valid", 32'(id_valid), 32'h1);
                checkOutput("flush_tgt_ir",    id_ir,         32'hA000_0040);
                checkOutput("flush_tgt_npc",   id_npc,        32'h41);
            end
            cycle();
        end
        idle(3);
        checkOutput("flush_drained", 32'(sb.size()), 32'h0);

        // Halt with two queued and one in flight: exactly three delivered.
        doReset();
        idle(3);
        for (int n = 1; n <= 3; n++) expectEntry(32'(n));
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
        #1;
        checkOutput("halt_count", 32'(fq_count), 32'h2);
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b1);
            #1;
            checkOutput("halt_imem_rd", 32'(imem_rd),   32'h0);
            checkOutput("halt_pc_held", 32'(imem_addr), 32'h3);
            checkOutput("halt_valid",   32'(id_valid),  (i < 3) ? 32'h1 : 32'h0);
            cycle();
        end
        expectEntry(32'h4);
        expectEntry(32'h5);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
            #1;
            if (i == 0) begin
                checkOutput("resume_imem_rd", 32'(imem_rd),   32'h1);
                checkOutput("resume_addr",    32'(imem_addr), 32'h3);
            end
            cycle();
        end
        idle(3);
        checkOutput("halt_drained", 32'(sb.size()), 32'h0);

        // Redirect while ID is ready and a response is arriving.
        doReset();
        expectEntry(32'h11);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
            cycle();
        end
        applyStimulus(1'b0, 1'b1, 32'h10, 1'b0, 1'b1);
        #1;
        checkOutput("rdpp_count_before", 32'(fq_count), 32'h1);
        checkOutput("rdpp_valid_masked", 32'(id_valid), 32'h0);
        cycle();
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        #1;
        checkOutput("rdpp_count_after", 32'(fq_count),  32'h0);
        checkOutput("rdpp_addr",        32'(imem_addr), 32'h10);
        cycle();
        cycle();
        #1;
        checkOutput("rdpp_npc", id_npc, 32'h11);
        cycle();
        idle(3);
        checkOutput("rdpp_drained", 32'(sb.size()), 32'h0);

        // Reset mid-stream with three queued and one in flight.
        doReset();
        idle(4);
        applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        #1;
        checkOutput("mrst_count_before", 32'(fq_count), 32'h3);
        checkOutput("mrst_imem_rd_rst",  32'(imem_rd),  32'h0);
        cycle();
        expectEntry(32'h1);
        expectEntry(32'h2);
        applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
        #1;
        checkOutput("mrst_valid",   32'(id_valid),  32'h0);
        checkOutput("mrst_count",   32'(fq_count),  32'h0);
        checkOutput("mrst_ir",      id_ir,          32'h0);
        checkOutput("mrst_npc",     id_npc,         32'h0);
        checkOutput("mrst_addr",    32'(imem_addr), 32'h0);
        checkOutput("mrst_imem_rd", 32'(imem_rd),   32'h1);
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
            cycle();
        end
        idle(3);
        checkOutput("mrst_drained", 32'(sb.size()), 32'h0);

        errors += sb_errors;
        checks += sb_checks;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
